// File: rtl/input_ctrl_if.sv
// ---------------------------------------------------------------------------
// input_ctrl_if : user-interface / controller bundle for input_ctrl
//
// Signals (names follow the datapath's board-level naming):
//   SW      [N]  raw asynchronous data switches
//   KEYb         raw asynchronous RUN pushbutton, 0 = pressed
//   EXTERN       controller grants the shared bus to this block
//   DONE         controller finished the current instruction
//   DIN     [N]  bus contribution (HELD when EXTERN, else zero)
//   RUN          one-cycle start request to the controller
//   BUSY         request outstanding, DONE not yet accepted
//   LED_IN  [N]  continuous mirror of the captured operand
//
// Modports:
//   master : environment side (switches, key, controller)
//   slave  : input_ctrl side
// ---------------------------------------------------------------------------
interface input_ctrl_if #(
  parameter int N = 10
);
  logic [N-1:0] SW;
  logic         KEYb;
  logic         EXTERN;
  logic         DONE;
  logic [N-1:0] DIN;
  logic         RUN;
  logic         BUSY;
  logic [N-1:0] LED_IN;

  modport master (
    output SW, KEYb, EXTERN, DONE,
    input  DIN, RUN, BUSY, LED_IN
  );

  modport slave (
    input  SW, KEYb, EXTERN, DONE,
    output DIN, RUN, BUSY, LED_IN
  );
endinterface

// File: rtl/input_ctrl.sv
// ---------------------------------------------------------------------------
// input_ctrl : input side of the processor datapath
//
// Synchronizes the data switches and the RUN key, debounces the key, and on
// a debounced press captures the switches into HELD and issues a one-cycle
// RUN to the controller. HELD is driven onto the shared bus while the
// controller asserts EXTERN. New requests are held off until DONE has been
// accepted and the key has been released.
//
// Ports:
//   CLK     system clock, all state on the rising edge
//   RESETb  asynchronous active-low reset
//   bus     input_ctrl_if.slave (SW, KEYb, EXTERN, DONE in;
//                                DIN, RUN, BUSY, LED_IN out)
//
// Parameters:
//   N                data/bus width
//   SYNC_STAGES      synchronizer depth on SW and KEYb (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a new
//                    key level
// ---------------------------------------------------------------------------
module input_ctrl #(
  parameter int N               = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         CLK,
  input  logic         RESETb,
  input_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("input_ctrl: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_WAIT_REL
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizers. Stage 0 samples the pad; the last stage is the only one
  // the rest of the block may look at.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]        key_sync;
  logic [SYNC_STAGES-1:0][N-1:0] sw_sync;
  logic                          key_s;
  logic [N-1:0]                  sw_s;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours; a blocking
  // assignment here would collapse the synchronizer into a single stage.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      key_sync <= '1;             // key chain resets to "released"
      sw_sync  <= '0;
    end else begin
      key_sync <= {key_sync[SYNC_STAGES-2:0], bus.KEYb};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], bus.SW};
    end
  end

  assign key_s = key_sync[SYNC_STAGES-1];
  assign sw_s  = sw_sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce. db_cnt counts consecutive edges on which the synchronized key
  // disagrees with the accepted level; the DEBOUNCE_CYCLES-th such edge
  // adopts the new level. press is a one-cycle pulse on an accepted
  // released-to-pressed change, so a held key can never retrigger.
  // -------------------------------------------------------------------------
  logic          key_db;
  logic [CW-1:0] db_cnt;
  logic          press;

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      key_db <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_s != key_db) begin
        if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          key_db <= key_s;
          db_cnt <= '0;
          press  <= ~key_s;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM
  // -------------------------------------------------------------------------
  state_t       state;
  state_t       next_state;
  logic [N-1:0] held;
  logic         busy_q;

  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:     if (press)   next_state = S_START;
      S_START:    next_state = bus.DONE ? S_WAIT_REL : S_BUSY;
      S_BUSY:     if (bus.DONE) next_state = S_WAIT_REL;
      S_WAIT_REL: if (key_db)  next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // HELD loads only on the edge entering START (reachable only from IDLE),
  // so it stays stable for the whole instruction. BUSY is registered from
  // the same next-state decode so it covers the START cycle and drops on
  // the edge that leaves START/BUSY.
  always_ff @(posedge CLK or negedge RESETb) begin
    if (!RESETb) begin
      held   <= '0;
      busy_q <= 1'b0;
    end else begin
      if (next_state == S_START) begin
        held <= sw_s;
      end
      busy_q <= (next_state == S_START) || (next_state == S_BUSY);
    end
  end

  always_comb begin
    bus.RUN    = (state == S_START);
    bus.BUSY   = busy_q;
    bus.LED_IN = held;
    bus.DIN    = bus.EXTERN ? held : '0;  // external bus OR/mux combines this
  end

endmodule

// File: tb/tb_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_ctrl : self-checking bench for input_ctrl
//
// A reference model tracks the key through a sample-history array, a
// stable-run length for debouncing, and three phase flags for the request
// life cycle. Directed steps cover latency, bus gating, hold-off, glitch
// rejection, DONE during START and asynchronous reset; a randomized tail
// exercises mixed key/switch/DONE/EXTERN activity.
// ---------------------------------------------------------------------------
module tb_input_ctrl;

  localparam int N   = 10;
  localparam int SS  = 2;
  localparam int DEB = 4;

  logic CLK = 1'b0;
  logic RESETb;

  input_ctrl_if #(.N(N)) bus ();

  input_ctrl #(
    .N              (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK   (CLK),
    .RESETb(RESETb),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic         m_key_hist [SS];    // [0] = most recent pad sample
  logic [N-1:0] m_sw_hist  [SS];
  logic         m_level;            // accepted key level, 1 = released
  int           m_run_len;          // edges the sampled key has disagreed
  logic         m_pressed_now;      // accepted press, visible next edge
  bit           m_in_start, m_in_work, m_in_release;
  logic [N-1:0] m_held;
  int           m_runs;             // requests the model has issued
  int           obs_runs;           // RUN cycles seen on the DUT
  int           win_runs;           // RUN cycles inside a directed window

  task automatic model_reset();
    for (int i = 0; i < SS; i++) begin
      m_key_hist[i] = 1'b1;
      m_sw_hist[i]  = '0;
    end
    m_level       = 1'b1;
    m_run_len     = 0;
    m_pressed_now = 1'b0;
    m_in_start    = 0;
    m_in_work     = 0;
    m_in_release  = 0;
    m_held        = '0;
  endtask

  // Advance the model by one rising edge using the inputs that edge sees.
  task automatic model_edge();
    logic         seen_key  = m_key_hist[SS-1];
    logic [N-1:0] seen_sw   = m_sw_hist[SS-1];
    logic         level_pre = m_level;
    logic         press_pre = m_pressed_now;
    bit idle = !m_in_start && !m_in_work && !m_in_release;

    if (idle) begin
      if (press_pre) begin
        m_in_start = 1;
        m_held     = seen_sw;
        m_runs++;
      end
    end else if (m_in_start) begin
      m_in_start = 0;
      if (bus.DONE) m_in_release = 1;
      else          m_in_work    = 1;
    end else if (m_in_work) begin
      if (bus.DONE) begin
        m_in_work    = 0;
        m_in_release = 1;
      end
    end else if (level_pre) begin
      m_in_release = 0;
    end

    m_pressed_now = 1'b0;
    if (seen_key != m_level) begin
      m_run_len++;
      if (m_run_len == DEB) begin
        m_level       = seen_key;
        m_run_len     = 0;
        m_pressed_now = (seen_key == 1'b0);
      end
    end else begin
      m_run_len = 0;
    end

    for (int i = SS - 1; i > 0; i--) begin
      m_key_hist[i] = m_key_hist[i-1];
      m_sw_hist[i]  = m_sw_hist[i-1];
    end
    m_key_hist[0] = bus.KEYb;
    m_sw_hist[0]  = bus.SW;
  endtask

  task automatic compare_all();
    check("run",    bus.RUN,    m_in_start);
    check("busy",   bus.BUSY,   m_in_start || m_in_work);
    check("led_in", bus.LED_IN, m_held);
    check("din",    bus.DIN,    bus.EXTERN ? m_held : '0);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (bus.RUN === 1'b1) begin
      obs_runs++;
      win_runs++;
    end
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    logic was_done;
    int   seg_len;
    logic seg_key;

    RESETb     = 1'b0;
    bus.SW     = '0;
    bus.KEYb   = 1'b1;
    bus.EXTERN = 1'b0;
    bus.DONE   = 1'b0;
    m_runs     = 0;
    obs_runs   = 0;
    model_reset();

    #12;
    check("reset_run",    bus.RUN,    1'b0);
    check("reset_busy",   bus.BUSY,   1'b0);
    check("reset_din",    bus.DIN,    '0);
    check("reset_led_in", bus.LED_IN, '0);
    @(negedge CLK);
    RESETb = 1'b1;
    steps(3);

    // Press with 2A5: RUN exactly during the cycle after edge SS+DEB+1.
    bus.SW     = 10'h2A5;
    bus.KEYb   = 1'b0;
    bus.EXTERN = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      check("latency_run", bus.RUN, (e == SS + DEB + 1));
      if (e == SS + DEB + 1) begin
        check("capture_led", bus.LED_IN, 10'h2A5);
        check("extern_din",  bus.DIN,    10'h2A5);
        bus.EXTERN = 1'b0;
        #1;
        check("no_extern_din", bus.DIN, '0);
        bus.EXTERN = 1'b1;
      end
    end

    // In BUSY: new switches, release and press again -> nothing queued.
    bus.SW   = 10'h155;
    win_runs = 0;
    bus.KEYb = 1'b1;
    steps(8);
    bus.KEYb = 1'b0;
    steps(8);
    check("busy_no_rerun", win_runs, 0);
    check("busy_held",     bus.LED_IN, 10'h2A5);

    // DONE with key still held -> WAIT_REL, no new request.
    bus.DONE = 1'b1;
    step();
    bus.DONE = 1'b0;
    check("done_busy_clear", bus.BUSY, 1'b0);
    steps(5);
    check("wait_rel_no_run", win_runs, 0);

    // Release, then a fresh press captures 155.
    bus.KEYb = 1'b1;
    steps(10);
    bus.KEYb = 1'b0;
    win_runs = 0;
    steps(10);
    check("repress_one_run", win_runs, 1);
    check("repress_held",    bus.LED_IN, 10'h155);
    check("busy_pre_reset",  bus.BUSY, 1'b1);

    // Asynchronous reset in the middle of the low clock phase.
    #2;
    RESETb   = 1'b0;
    bus.KEYb = 1'b1;
    #1;
    check("async_rst_run",    bus.RUN,    1'b0);
    check("async_rst_busy",   bus.BUSY,   1'b0);
    check("async_rst_din",    bus.DIN,    '0);
    check("async_rst_led_in", bus.LED_IN, '0);
    model_reset();
    #1;
    RESETb   = 1'b1;
    win_runs = 0;
    steps(10);
    check("post_reset_no_run", win_runs, 0);

    // Glitch shorter than the debounce window.
    bus.KEYb = 1'b0;
    steps(3);
    bus.KEYb = 1'b1;
    steps(10);
    check("glitch_no_run", win_runs, 0);

    // DONE during the START cycle -> WAIT_REL, BUSY low afterwards.
    bus.SW   = 10'h3C3;
    bus.KEYb = 1'b0;
    was_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (was_done) check("done_in_start_busy", bus.BUSY, 1'b0);
      was_done = m_in_start;
      bus.DONE = m_in_start;
    end
    bus.DONE = 1'b0;
    check("done_in_start_one_run", win_runs, 1);

    // Key held across repeated DONE for 20 cycles -> no further RUN.
    win_runs = 0;
    for (int i = 0; i < 20; i++) begin
      bus.DONE = i[0];
      step();
    end
    bus.DONE = 1'b0;
    check("held_no_rerun", win_runs, 0);
    bus.KEYb = 1'b1;
    steps(10);
    bus.KEYb = 1'b0;
    steps(10);
    check("release_repress", win_runs, 1);

    // Randomized tail: key segments of random length and level.
    bus.KEYb = 1'b1;
    steps(10);
    for (int seg = 0; seg < 80; seg++) begin
      seg_key = $urandom_range(0, 1);
      seg_len = $urandom_range(1, 12);
      for (int c = 0; c < seg_len; c++) begin
        bus.KEYb   = seg_key;
        bus.SW     = N'($urandom);
        bus.EXTERN = ($urandom_range(0, 3) != 0);
        bus.DONE   = ($urandom_range(0, 4) == 0);
        step();
      end
    end
    bus.DONE = 1'b0;
    bus.KEYb = 1'b1;
    steps(12);
    check("total_runs", obs_runs, m_runs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
